spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//  SPI responder (slave) matching the codebase's SPI initiator; SPI mode 0 (CPOL=0, CPHA=0), MSB first.
//  Oversamples spi_sck/spi_mosi/spi_cs_n in the apb_clk domain, shifts full-duplex DATA_W-bit frames.
//  Single-entry TX holding buffer and single-entry RX holding register, each with a handshake.
//  Sits on the peripheral side of a board/SoC link; the register wrapper maps these handshakes onto APB.
// PARAMETERS
//  DATA_W       8  frame width in bits (>=2)
//  SYNC_STAGES  2  synchroniser flops on spi_sck, spi_mosi, spi_cs_n (>=2)
// PORTS
//  apb_clk     in   1       system clock; all logic on rising edge
//  apb_rst     in   1       asynchronous, active-low reset
//  spi_sck     in   1       SPI clock from initiator
//  spi_mosi    in   1       serial data from initiator
//  spi_cs_n    in   1       active-low select (one bit of initiator's spi_cs)
//  spi_miso    out  1       serial data to initiator; 0 when not selected
//  tx_data     in   DATA_W  next byte to return
//  tx_valid    in   1       tx_data valid; accepted when tx_valid & tx_ready
//  tx_ready    out  1       TX buffer empty
//  rx_data     out  DATA_W  last completed received frame
//  rx_valid    out  1       rx_data unread; held until rx_ack
//  rx_ack      in   1       consumer has read rx_data
//  rx_ovr      out  1       sticky: frame completed while rx_valid=1
//  tx_udr      out  1       sticky: frame started with empty TX buffer
//  err_clr     in   1       clears rx_ovr and tx_udr
//  busy        out  1       synchronised spi_cs_n is low
// BEHAVIOUR
//  - Reset: spi_miso=0, tx_ready=1, rx_data=0, rx_valid=0, rx_ovr=0, tx_udr=0, busy=0, bit_cnt=0, FSM=IDLE.
//    Synchroniser flops reset to sck=0, cs_n=1, mosi=0.
//  - Constraint: SCK high and low phases each >= 4 apb_clk cycles, i.e. f_sck <= f_clk/8.
//  - Edge events use synchronised signals: rise/fall = sck_s vs sck_s_d; csfall/csrise likewise on cs_n.
//  - FSM IDLE -> SHIFT on csfall:
//      shreg <= buffer, or 0 if buffer empty (set tx_udr); buffer freed (tx_ready=1); bit_cnt=0.
//  - SHIFT on rise: shift spi_mosi (sync) into rx shift reg LSB; bit_cnt++.
//      At bit_cnt==DATA_W-1: rx_data <= assembled frame, rx_valid=1 next cycle,
//      rx_ovr set if rx_valid was already 1 and no rx_ack this cycle; bit_cnt wraps to 0.
//  - SHIFT on fall: bit_cnt==0 (frame boundary, cs_n still low) -> reload shreg from buffer as at csfall;
//    otherwise shreg <= shreg<<1.
//  - spi_miso = shreg[DATA_W-1] while busy, else 0.
//    First MSB valid SYNC_STAGES+1 clk after spi_cs_n falls; initiator must wait >= half SCK period.
//  - SHIFT -> IDLE on csrise, checked before edges. A partial frame is discarded (no rx_valid, no rx_ovr);
//    bit_cnt=0. A byte already loaded into shreg is consumed; the buffer is untouched.
//  - TX buffer: loads on tx_valid & tx_ready. If load and shreg reload coincide with the buffer empty,
//    the reload sends 0 with tx_udr set, and tx_data stays in the buffer for the next frame.
//  - rx_ack clears rx_valid. A new frame completing in the same cycle as rx_ack -> rx_valid stays 1, no ovr.
//    Overrun overwrites rx_data with the newest frame.
//  - err_clr clears both stickies; a same-cycle set wins.
//  - Async reset mid-frame: immediate return to reset state; the next frame starts only on a fresh csfall.
// TESTING
//  1 Reset asserted mid-frame -> all outputs at reset values within 0 clk; tx_ready=1.
//  2 Preload tx 0xA5; initiator sends 0x3C at f_clk/8 ->
//    miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1; tx_ready=1 after csfall.
//  3 cs_n held low for 2 frames; tx 0x12 then 0x34; initiator sends 0xC3, 0x5A ->
//    miso 0x12,0x34; rx_data 0xC3 then 0x5A with rx_ack between; no flags.
//  4 No tx preload, one frame -> miso 0x00, tx_udr=1; err_clr pulse -> tx_udr=0.
//  5 Two frames 0x11, 0x22 without rx_ack -> rx_data=0x22, rx_ovr=1; rx_ack -> rx_valid=0, rx_ovr stays 1.
//  6 cs_n rises after 5 SCK cycles -> no rx_valid, busy=0;
//    next full frame with mosi 0x81 -> rx_data=0x81 correct.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder (CPOL=0, CPHA=0), MSB first.
// spi_sck, spi_mosi and spi_cs_n are oversampled in the apb_clk domain.
// The block shifts full-duplex DATA_W-bit frames. It has a single-entry TX
// holding buffer and a single-entry RX holding register, each with a
// valid/ready or valid/ack handshake. It also keeps sticky overrun and
// underrun flags.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              apb_clk,
    input  logic              apb_rst,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic              spi_miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_ovr,
    output logic              tx_udr,
    input  logic              err_clr,
    output logic              busy
);

    localparam int              CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // Synchroniser chains. Index 0 is the first stage.
    logic [SYNC_STAGES-1:0] sck_sync_q,  sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    // Delayed copies of the synchronised signals, used for edge detection.
    logic                   sck_dly_q,   sck_dly_d;
    logic                   cs_dly_q,    cs_dly_d;

    state_t                 state_q,     state_d;
    logic [CNT_W-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [DATA_W-1:0]      tx_shreg_q,  tx_shreg_d;
    logic [DATA_W-1:0]      rx_shreg_q,  rx_shreg_d;
    logic [DATA_W-1:0]      tx_buf_q,    tx_buf_d;
    logic                   buf_full_q,  buf_full_d;
    logic [DATA_W-1:0]      rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   rx_ovr_q,    rx_ovr_d;
    logic                   tx_udr_q,    tx_udr_d;
    logic                   miso_q,      miso_d;

    logic                   sck_s, mosi_s, cs_s;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;
    logic                   reload;
    logic [DATA_W-1:0]      rx_frame;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_dly_q;
    assign sck_fall = ~sck_s & sck_dly_q;
    assign cs_fall  = ~cs_s & cs_dly_q;
    assign cs_rise  = cs_s & ~cs_dly_q;

    assign spi_miso = miso_q;
    assign tx_ready = ~buf_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_ovr   = rx_ovr_q;
    assign tx_udr   = tx_udr_q;
    assign busy     = ~cs_s;

    // Next-state logic: synchronisers, frame FSM, shift registers, handshakes and flags.
    always_comb begin
        // NOTE: every _d starts as its _q so that no path through this block infers a latch.
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        sck_dly_d   = sck_s;
        cs_dly_d    = cs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shreg_d  = tx_shreg_q;
        rx_shreg_d  = rx_shreg_q;
        tx_buf_d    = tx_buf_q;
        buf_full_d  = buf_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        rx_ovr_d    = rx_ovr_q;
        tx_udr_d    = tx_udr_q;
        reload      = 1'b0;
        rx_frame    = {rx_shreg_q[DATA_W-2:0], mosi_s};

        // Clears come first, so that a set in the same cycle wins.
        if (err_clr) begin
            rx_ovr_d = 1'b0;
            tx_udr_d = 1'b0;
        end
        if (rx_ack) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    reload    = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Deselect takes priority over SCK edges. A partial frame is dropped.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else begin
                    if (sck_rise) begin
                        rx_shreg_d = rx_frame;
                        if (bit_cnt_q == BIT_LAST) begin
                            rx_data_d  = rx_frame;
                            rx_valid_d = 1'b1;
                            if (rx_valid_q && !rx_ack) begin
                                rx_ovr_d = 1'b1;
                            end
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (sck_fall) begin
                        // The counter is zero only at a frame boundary, so the next byte is loaded there.
                        if (bit_cnt_q == '0) begin
                            reload = 1'b1;
                        end else begin
                            tx_shreg_d = tx_shreg_q << 1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The shift register is loaded from the holding buffer. An empty buffer sends zeros.
        if (reload) begin
            if (buf_full_q) begin
                tx_shreg_d = tx_buf_q;
                buf_full_d = 1'b0;
            end else begin
                tx_shreg_d = '0;
                tx_udr_d   = 1'b1;
            end
        end

        // A buffer write is gated by the current ready. If it coincides with a reload of an
        // empty buffer, the new byte waits in the buffer for the next frame.
        if (tx_valid && !buf_full_q) begin
            tx_buf_d   = tx_data;
            buf_full_d = 1'b1;
        end

        miso_d = (state_d == ST_SHIFT) ? tx_shreg_d[DATA_W-1] : 1'b0;
    end

    // State registers, all cleared asynchronously to the idle, deselected condition.
    always_ff @(posedge apb_clk or negedge apb_rst) begin
        if (!apb_rst) begin
            // NOTE: every flop here, including the data registers, has a reset value, so that an
            // abort mid-frame returns to a fully known state.
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sck_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            tx_shreg_q  <= '0;
            rx_shreg_q  <= '0;
            tx_buf_q    <= '0;
            buf_full_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            tx_udr_q    <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling its pre-edge inputs.
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sck_dly_q   <= sck_dly_d;
            cs_dly_q    <= cs_dly_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shreg_q  <= tx_shreg_d;
            rx_shreg_q  <= rx_shreg_d;
            tx_buf_q    <= tx_buf_d;
            buf_full_q  <= buf_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            tx_udr_q    <= tx_udr_d;
            miso_q      <= miso_d;
        end
    end

endmodule
